// File: rtl/fp_align_stage.sv
// FP32 operand-alignment stage feeding the adder core: orders operands by magnitude,
// then shifts the smaller significand right a few bits per cycle while collecting sticky.
module fp_align_stage #(
  parameter int SHIFT_PER_CYCLE = 4,
  parameter int SAT_D           = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_l_mant,
  output logic [25:0] out_s_mant,
  output logic        out_sticky,
  output logic        out_l_sign,
  output logic        out_s_sign,
  output logic [7:0]  out_exp,
  output logic        out_special
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [25:0] r_l_mant;
  logic [25:0] r_s_mant;
  logic        r_sticky;
  logic        r_l_sign;
  logic        r_s_sign;
  logic [7:0]  r_exp;
  logic        r_special;
  logic        r_out_valid;
  logic [7:0]  r_rem;

  logic        w_accept;
  logic        w_a_is_l;
  logic [31:0] w_l_op;
  logic [31:0] w_s_op;
  logic [7:0]  w_l_eexp;
  logic [7:0]  w_s_eexp;
  logic [7:0]  w_d;
  logic [25:0] w_l_mant_cap;
  logic [25:0] w_s_mant_cap;
  logic        w_special;
  logic        w_no_shift;
  logic        w_sat;
  logic [7:0]  w_amt;
  logic [25:0] w_s_shifted;
  logic        w_shift_sticky;

  function automatic logic [7:0] f_shift_amt(input logic [7:0] rem);
    logic [7:0] step;
    step = 8'(SHIFT_PER_CYCLE);
    return (rem > step) ? step : rem;
  endfunction

  function automatic logic f_shifted_out(input logic [25:0] mant, input logic [7:0] amt);
    logic [25:0] mask;
    mask = (26'd1 << amt) - 26'd1;
    return |(mant & mask);
  endfunction

  function automatic logic [7:0] f_eff_exp(input logic [7:0] exp);
    return (exp == 8'd0) ? 8'd1 : exp;
  endfunction

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

  // Capture: magnitude order ignores sign; a tie selects in_b as the larger operand.
  assign w_a_is_l     = (in_a[30:0] > in_b[30:0]);
  assign w_l_op       = w_a_is_l ? in_a : in_b;
  assign w_s_op       = w_a_is_l ? in_b : in_a;
  assign w_l_eexp     = f_eff_exp(w_l_op[30:23]);
  assign w_s_eexp     = f_eff_exp(w_s_op[30:23]);
  assign w_d          = w_l_eexp - w_s_eexp;
  assign w_l_mant_cap = {(w_l_op[30:23] != 8'd0), w_l_op[22:0], 2'b00};
  assign w_s_mant_cap = {(w_s_op[30:23] != 8'd0), w_s_op[22:0], 2'b00};
  assign w_special    = (&in_a[30:23]) | (&in_b[30:23]);
  assign w_sat        = (w_d >= 8'(SAT_D));
  assign w_no_shift   = w_special || (w_d == 8'd0) || w_sat;

  // Shift: at most SHIFT_PER_CYCLE bits per cycle.
  assign w_amt          = f_shift_amt(r_rem);
  assign w_s_shifted    = r_s_mant >> w_amt;
  assign w_shift_sticky = f_shifted_out(r_s_mant, w_amt);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = w_no_shift ? HOLD : SHIFT;
      SHIFT: if (r_rem == w_amt) w_state_nxt = HOLD;
      HOLD:  if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_l_mant    <= '0;
      r_s_mant    <= '0;
      r_sticky    <= 1'b0;
      r_l_sign    <= 1'b0;
      r_s_sign    <= 1'b0;
      r_exp       <= '0;
      r_special   <= 1'b0;
      r_rem       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == HOLD);
      if (r_state == IDLE && w_accept) begin
        r_l_mant  <= w_l_mant_cap;
        r_l_sign  <= w_l_op[31];
        r_s_sign  <= w_s_op[31];
        r_exp     <= w_l_eexp;
        r_special <= w_special;
        r_rem     <= w_d;
        if (!w_special && w_sat) begin
          r_s_mant <= '0;
          r_sticky <= |w_s_mant_cap;
        end else begin
          r_s_mant <= w_s_mant_cap;
          r_sticky <= 1'b0;
        end
      end else if (r_state == SHIFT) begin
        r_s_mant <= w_s_shifted;
        r_sticky <= r_sticky | w_shift_sticky;
        r_rem    <= r_rem - w_amt;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_l_mant  = r_l_mant;
  assign out_s_mant  = r_s_mant;
  assign out_sticky  = r_sticky;
  assign out_l_sign  = r_l_sign;
  assign out_s_sign  = r_s_sign;
  assign out_exp     = r_exp;
  assign out_special = r_special;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: vector table plus backpressure and reset sequences.
module tb_fp_align_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_l_mant;
  logic [25:0] out_s_mant;
  logic        out_sticky;
  logic        out_l_sign;
  logic        out_s_sign;
  logic [7:0]  out_exp;
  logic        out_special;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [25:0] l_mant;
    logic [25:0] s_mant;
    logic        sticky;
    logic        l_sign;
    logic        s_sign;
    logic [7:0]  exp;
    logic        special;
  } vec_t;

  localparam int NV = 13;
  vec_t  vecs [NV];
  string names [NV];

  fp_align_stage #(.SHIFT_PER_CYCLE(4), .SAT_D(27)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_l_mant(out_l_mant), .out_s_mant(out_s_mant), .out_sticky(out_sticky),
    .out_l_sign(out_l_sign), .out_s_sign(out_s_sign), .out_exp(out_exp),
    .out_special(out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input int lat,
                              input logic [25:0] lm, input logic [25:0] sm, input logic st,
                              input logic ls, input logic ss, input logic [7:0] e,
                              input logic sp);
    vec_t v;
    v.a = a; v.b = b; v.lat = lat; v.l_mant = lm; v.s_mant = sm; v.sticky = st;
    v.l_sign = ls; v.s_sign = ss; v.exp = e; v.special = sp;
    return v;
  endfunction

  // Issue one operand pair and wait (bounded) for out_valid; returns edges counted from accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int lat;
    string n;
    v = vecs[idx];
    n = names[idx];
    issue(v.a, v.b, lat);
    chk({n, ".latency"}, 32'(lat), 32'(v.lat));
    chk({n, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({n, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({n, ".l_mant"}, 32'(out_l_mant), 32'(v.l_mant));
    chk({n, ".s_mant"}, 32'(out_s_mant), 32'(v.s_mant));
    chk({n, ".sticky"}, 32'(out_sticky), 32'(v.sticky));
    chk({n, ".l_sign"}, 32'(out_l_sign), 32'(v.l_sign));
    chk({n, ".s_sign"}, 32'(out_s_sign), 32'(v.s_sign));
    chk({n, ".exp"}, 32'(out_exp), 32'(v.exp));
    chk({n, ".special"}, 32'(out_special), 32'(v.special));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({n, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({n, ".ready_back"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [25:0] snap_l, snap_s;
    logic [7:0]  snap_e;
    logic        snap_st;
    logic        stale;

    vecs[0]  = mk(32'h3F800000, 32'h40000000, 2, 26'h2000000, 26'h1000000, 0, 0, 0, 8'h80, 0);
    names[0] = "d1";
    vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1, 26'h2000000, 26'h2000000, 0, 0, 0, 8'h7F, 0);
    names[1] = "tie";
    vecs[2]  = mk(32'h4B800000, 32'h3F800001, 7, 26'h2000000, 26'h0000002, 1, 0, 0, 8'h97, 0);
    names[2] = "d24";
    vecs[3]  = mk(32'h4F000000, 32'h3F800000, 1, 26'h2000000, 26'h0000000, 1, 0, 0, 8'h9E, 0);
    names[3] = "sat31";
    vecs[4]  = mk(32'h7F800000, 32'h3F800000, 1, 26'h2000000, 26'h2000000, 0, 0, 0, 8'hFF, 1);
    names[4] = "inf";
    vecs[5]  = mk(32'hC0000000, 32'h3F800000, 2, 26'h2000000, 26'h1000000, 0, 1, 0, 8'h80, 0);
    names[5] = "signs";
    vecs[6]  = mk(32'h42000000, 32'h3F800003, 3, 26'h2000000, 26'h0100000, 1, 0, 0, 8'h84, 0);
    names[6] = "d5";
    vecs[7]  = mk(32'h4C800000, 32'h3F800000, 8, 26'h2000000, 26'h0000000, 1, 0, 0, 8'h99, 0);
    names[7] = "d26";
    vecs[8]  = mk(32'h4D000000, 32'h3F800000, 1, 26'h2000000, 26'h0000000, 1, 0, 0, 8'h9A, 0);
    names[8] = "d27sat";
    vecs[9]  = mk(32'h00000001, 32'h00000000, 1, 26'h0000004, 26'h0000000, 0, 0, 0, 8'h01, 0);
    names[9] = "denorm";
    vecs[10] = mk(32'h00800000, 32'h00400000, 1, 26'h2000000, 26'h1000000, 0, 0, 0, 8'h01, 0);
    names[10] = "minnorm";
    vecs[11] = mk(32'h3F800000, 32'h7FC00000, 1, 26'h3000000, 26'h2000000, 0, 0, 0, 8'hFF, 1);
    names[11] = "nan";
    vecs[12] = mk(32'h41800000, 32'h3F800000, 2, 26'h2000000, 26'h0200000, 0, 0, 0, 8'h83, 0);
    names[12] = "d4";

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.l_mant", 32'(out_l_mant), 32'd0);
    chk("reset.s_mant", 32'(out_s_mant), 32'd0);
    chk("reset.exp", 32'(out_exp), 32'd0);
    chk("reset.sticky", 32'(out_sticky), 32'd0);
    chk("reset.special", 32'(out_special), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: outputs frozen in HOLD, in_valid pulses ignored.
    issue(32'h3F800000, 32'h40000000, lat);
    chk("bp.latency", 32'(lat), 32'd2);
    snap_l = out_l_mant; snap_s = out_s_mant; snap_e = out_exp; snap_st = out_sticky;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_a = 32'h40400000; in_b = 32'h4B800000;
      @(posedge clk); #1;
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.l_mant", 32'(out_l_mant), 32'(snap_l));
      chk("bp.s_mant", 32'(out_s_mant), 32'h1000000);
      chk("bp.exp", 32'(out_exp), 32'h80);
      chk("bp.stable", {snap_s, snap_e[3:0], snap_st, 1'b0}, {out_s_mant, out_exp[3:0], out_sticky, 1'b0});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_extra_txn", 32'(out_valid), 32'd0);

    // Reset during SHIFT of the d=24 case.
    @(negedge clk);
    in_a = 32'h4B800000; in_b = 32'h3F800001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_shift_ready", 32'(in_ready), 32'd0);
    chk("rst.in_shift_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.async_valid", 32'(out_valid), 32'd0);
    chk("rst.async_ready", 32'(in_ready), 32'd1);
    chk("rst.async_s_mant", 32'(out_s_mant), 32'd0);
    chk("rst.async_exp", 32'(out_exp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("rst.no_stale_output", 32'(stale), 32'd0);
    chk("rst.idle_after", 32'(in_ready), 32'd1);

    run_vec(0);
    run_vec(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
